// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: capture-FSM state encoding, default RX FIFO depth
// and the default baud divisor for a 50 MHz system clock.
// -----------------------------------------------------------------------------
package uart_pkg;

   // Capture FSM: IDLE waits for a ready byte, CLEAR waits for the receiver
   // to drop its ready flag so a byte is never taken twice.
   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } cap_state_e;

   localparam int UART_RX_DEPTH   = 8;
   // 50 MHz / (115200 * 16) = 27.1 -> 27 system clocks per oversample tick.
   localparam int UART_DIV_115200 = 27;

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Byte FIFO between the UART capture logic and the consumer. Flop-based
// storage; head byte and occupancy are taken straight from registered state.
//
// Ports
//   clk_50m   : clock, rising edge
//   rst       : asynchronous active-high reset
//   push      : write push_data this cycle (accepted if not full, or if a
//               pop happens in the same cycle)
//   push_data : byte to write
//   pop       : remove the head byte (ignored when empty)
//   head      : current head byte
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : bytes held, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_50m,
   input  logic          rst,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    head,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q,  count_d;
   logic          push_ok, pop_ok;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // A push into a full FIFO still fits when the head leaves on the same edge;
   // the write then lands on the slot being vacated.
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      // Pointers are AW bits wide, so DEPTH being a power of two gives the
      // modulo-DEPTH wrap for free.
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: the storage is reset along with the pointers because the head byte
   // is read straight from it and must read 0 while reset is asserted; at this
   // depth the cost of resettable flops is negligible.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push_ok) mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Control wrapper around a UART receiver: generates the 16x oversample tick,
// captures each ready byte exactly once into an RX FIFO, and presents the FIFO
// head on a valid/ready stream with a sticky overrun flag.
//
// Ports
//   clk_50m      : sole clock, rising edge
//   rst          : asynchronous active-high reset
//   enable       : 1 runs the tick generator and lets the FIFO/overrun change
//   baud_div     : system clocks per oversample tick (0 and 1 both mean 1)
//   rx_clken     : one-cycle oversample tick to the receiver
//   rx_ready     : receiver has a byte
//   rx_data      : receiver byte
//   rx_ready_clr : one-cycle request to clear the receiver's ready flag
//   m_data       : FIFO head byte
//   m_valid      : FIFO non-empty
//   m_ready      : consumer takes the head byte
//   fifo_count   : bytes held, 0..DEPTH
//   overrun      : sticky, a byte was dropped on a full FIFO
//   overrun_clr  : clears overrun (a same-cycle overrun event wins)
// -----------------------------------------------------------------------------
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_RX_DEPTH,
   parameter int DIV_W = 16
) (
   input  logic                     clk_50m,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [DIV_W-1:0]         baud_div,
   output logic                     rx_clken,
   input  logic                     rx_ready,
   input  logic [7:0]               rx_data,
   output logic                     rx_ready_clr,
   output logic [7:0]               m_data,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overrun,
   input  logic                     overrun_clr
);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [DIV_W-1:0] div_eff;
   logic             clken_q,   clken_d;
   cap_state_e       state_q,   state_d;
   logic             clr_q,     clr_d;
   logic             overrun_q, overrun_d;
   logic             push_req, push, pop;
   logic             fifo_full, fifo_empty;

   // ---------------- oversample tick ----------------
   assign div_eff = (baud_div > DIV_W'(1)) ? baud_div : DIV_W'(1);

   // Wrap on ">=" rather than "==" so a divisor lowered below the running
   // count ticks on the next cycle instead of counting all the way round.
   always_comb begin
      div_cnt_d = div_cnt_q + DIV_W'(1);
      clken_d   = 1'b0;
      if (!enable) begin
         div_cnt_d = '0;
      end else if (({1'b0, div_cnt_q} + (DIV_W+1)'(1)) >= {1'b0, div_eff}) begin
         div_cnt_d = '0;
         clken_d   = 1'b1;
      end
   end

   // ---------------- capture FSM ----------------
   always_comb begin
      state_d  = state_q;
      clr_d    = 1'b0;
      push_req = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_ready) begin
               push_req = 1'b1;
               clr_d    = 1'b1;
               state_d  = CLEAR;
            end
         end
         CLEAR: begin
            if (!rx_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // The FSM keeps handshaking while disabled, but the FIFO and overrun flag
   // are frozen: captured bytes are discarded.
   assign push = push_req && enable;
   assign pop  = m_valid && m_ready && enable;

   always_comb begin
      overrun_d = overrun_q;
      if (enable) begin
         if (overrun_clr)                    overrun_d = 1'b0;
         if (push && fifo_full && !pop)      overrun_d = 1'b1;
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk_50m or posedge rst) begin
      if (rst) begin
         div_cnt_q <= '0;
         clken_q   <= 1'b0;
         state_q   <= IDLE;
         clr_q     <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         clken_q   <= clken_d;
         state_q   <= state_d;
         clr_q     <= clr_d;
         overrun_q <= overrun_d;
      end
   end

   // ---------------- RX FIFO ----------------
   uart_rx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_50m   (clk_50m),
      .rst       (rst),
      .push      (push),
      .push_data (rx_data),
      .pop       (pop),
      .head      (m_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign m_valid      = !fifo_empty;
   assign rx_clken     = clken_q;
   assign rx_ready_clr = clr_q;
   assign overrun      = overrun_q;

endmodule
